// File: rtl/fetch_pc_unit.sv
// Fetch PC register and next-PC selection with delay-slot redirects, a one-entry pending redirect and exception flush.
// Latency: a redirect appears on pc_o one cycle after the resolving edge, or on the first advance edge if fetch was blocked.
// Backpressure: stall_i or a low imem_ready_i holds the PC; a redirect taken while imem_ready_i is low waits in the pending register.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        flush_i,
    input  logic        br_valid_i,
    input  logic [1:0]  br_kind_i,
    input  logic        cmp_i,
    input  logic [31:0] id_pc_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] index26_i,
    input  logic [31:0] rs_value_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        pending_o,
    output logic        adel_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [0:0]  state;
    logic [31:0] pending_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] target;
    logic        taken;
    logic        advance;

    assign id_pc_plus4 = id_pc_i + 32'd4;
    assign br_offset   = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        target = id_pc_plus4 + br_offset;
        case (br_kind_i)
            2'd2:    target = {id_pc_plus4[31:28], index26_i, 2'b00};
            2'd3:    target = rs_value_i;
            default: target = id_pc_plus4 + br_offset;
        endcase
    end

    assign taken   = br_valid_i & (((br_kind_i == 2'd1) & cmp_i) |
                                   (br_kind_i == 2'd2) | (br_kind_i == 2'd3));
    assign advance = imem_ready_i & ~stall_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_o       <= RESET_PC;
            state      <= IDLE;
            pending_pc <= 32'd0;
        end else if (flush_i) begin
            pc_o       <= EXC_PC;
            state      <= IDLE;
            pending_pc <= 32'd0;
        end else if (state == PENDING) begin
            // Branches in ID are ignored here: the buffered target already belongs to an older transfer.
            if (advance) begin
                pc_o  <= pending_pc;
                state <= IDLE;
            end
        end else if (!stall_i) begin
            if (taken && imem_ready_i) begin
                pc_o <= target;
            end else if (taken) begin
                pending_pc <= target;
                state      <= PENDING;
            end else if (imem_ready_i) begin
                pc_o <= pc_plus4_o;
            end
        end
    end

    assign pc_plus4_o = pc_o + 32'd4;
    assign pending_o  = (state == PENDING);
    assign adel_o     = (pc_o[1:0] != 2'b00);

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage PC register and next-PC selector for the 5-stage MIPS pipeline.
- Consumes the ID-stage branch decision (comparator result plus control-transfer kind) and redirects instruction fetch using MIPS delay-slot semantics.
- Honours hazard stalls and instruction-memory back-pressure, and takes exception redirects at top priority.
- A taken redirect that arrives while fetch is blocked is buffered in a one-entry pending register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry loaded on flush.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard stall from ID; holds PC and ignores br_valid_i.
- imem_ready_i  in  1  instruction memory accepted the fetch at pc_o this cycle.
- flush_i  in  1  exception redirect request.
- br_valid_i  in  1  ID holds a control-transfer instruction this cycle.
- br_kind_i  in  2  0 none, 1 conditional branch, 2 j/jal, 3 jr/jalr.
- cmp_i  in  1  branch condition result from the ID comparator.
- id_pc_i  in  32  PC of the instruction in ID.
- imm16_i  in  16  branch offset field.
- index26_i  in  26  jump index field.
- rs_value_i  in  32  forwarded rs value, used by jr/jalr.
- pc_o  out  32  current fetch PC (registered).
- pc_plus4_o  out  32  pc_o + 4 (combinational).
- pending_o  out  1  high while a buffered redirect is waiting.
- adel_o  out  1  pc_o[1:0] != 0, fetch address misaligned.

Behaviour:
- Reset, asynchronous: pc_o=RESET_PC, state=IDLE, pending_pc=0, pending_o=0, adel_o=0.
- Target arithmetic, all 32-bit with wrap-around and no overflow trap:
  - Kind 1: id_pc_i + 4 + (sign_ext(imm16_i) << 2).
  - Kind 2: {id_pc_i_plus4[31:28], index26_i, 2'b00}.
  - Kind 3: rs_value_i, used unmodified. Misaligned values are loaded and flagged on adel_o.
- taken = br_valid_i & (kind==1 & cmp_i | kind==2 | kind==3). Kind 0 is never taken.
- advance = imem_ready_i & ~stall_i.
- Delay slot: when the branch is in ID, IF already holds id_pc_i+4. The target is therefore the PC fetched after the delay slot, and the delay slot is never squashed.
- Priority, per clock edge:
  1. flush_i: pc_o<=EXC_PC, state<=IDLE, pending cleared. Ignores stall, ready and branch inputs.
  2. State IDLE:
     - stall_i=1: hold everything; br_valid_i is ignored because ID will re-present the branch.
     - taken and imem_ready_i=1: pc_o<=target.
     - taken and imem_ready_i=0: pending_pc<=target, state<=PENDING, pc_o held.
     - Otherwise, if advance: pc_o<=pc_o+4.
     - Otherwise hold.
  3. State PENDING:
     - br_valid_i is ignored.
     - advance: pc_o<=pending_pc, state<=IDLE.
     - Otherwise hold. pending_pc is not overwritten.
- pending_o = (state==PENDING).
- Latency: redirect is visible on pc_o one cycle after the resolving edge when memory is ready, else on the first advance edge.
- A flush during PENDING discards pending_pc.
- Reset mid-operation returns to the reset values immediately; no partial update.
- 32'hFFFF_FFFC + 4 wraps to 0.

Test Plan:
- Reset then 3 cycles with imem_ready_i=1, stall_i=0 -> pc_o 3000, 3004, 3008, 300C. adel_o=0, pending_o=0.
- Kind 1, cmp_i=1, id_pc_i=3008, imm16_i=FFFE, ready=1 -> next pc_o=3004. Same stimulus with cmp_i=0 -> pc_o+4.
- Kind 2, id_pc_i=3010, index26_i=0x0000C40 -> pc_o=00003100. Kind 3, rs_value_i=00003202 -> pc_o=00003202, adel_o=1.
- Kind 1 taken to 3040 with imem_ready_i=0 for 3 cycles -> pc_o held and pending_o=1 for 3 cycles. On the first ready cycle pc_o=3040 and pending_o drops.
- stall_i=1 with a taken branch for 2 cycles -> pc_o unchanged and no pending state. Release with ready=1 -> pc_o=target.
- flush_i while PENDING, and separately while stalled -> pc_o=00004180, pending_o=0. Assert reset_n=0 mid-PENDING -> pc_o=00003000 immediately.
